// File: rtl/my_if_rx_fifo.sv
// my_if_rx_fifo: receive stage for the my_if valid/data/ready handshake.
// The block buffers producer bytes in a small first-word-fall-through FIFO and
// presents them again on a second valid/ready port.
// in_ready is derived from the registered occupancy only, so the producer sees a
// clean, registered back-pressure point. A full FIFO never passes data through.
// Optional build macro: MY_IF_RX_STATS_EN adds the stat_accepted and stat_stalled
// counters. The datapath is the same with or without the macro.
module my_if_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [LW-1:0]     level
`ifdef MY_IF_RX_STATS_EN
  ,
  output logic [15:0]       stat_accepted,
  output logic [15:0]       stat_stalled
`endif
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push, pop;

  assign in_ready  = (level_q != FULL_LVL);
  assign out_valid = (level_q != '0);
  // The output reads as zero while the FIFO is empty, so stale storage never shows.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Storage is written only on an accepted push. A flush drops that cycle's byte.
  // The storage array has no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

  // Next-state logic for the pointers and the occupancy.
  // A flush has priority over both push and pop.
  // A push and a pop in the same cycle leave the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State register for the pointers and the occupancy. Reset clears it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef MY_IF_RX_STATS_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] stl_q, stl_d;

  // The counters wrap naturally. A flush does not clear them; only reset does.
  always_comb begin
    acc_d = acc_q;
    stl_d = stl_q;
    if (push)                  acc_d = acc_q + 16'd1;
    if (in_valid && !in_ready) stl_d = stl_q + 16'd1;
  end

  // Register for the statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      stl_q <= '0;
    end else begin
      acc_q <= acc_d;
      stl_q <= stl_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_stalled  = stl_q;
`endif

endmodule

// File: tb/tb_my_if_rx_fifo.sv
// Testbench for my_if_rx_fifo.
// The reference model is a byte queue that holds the FIFO contents.
// Every cycle the bench compares the DUT outputs against that queue.
// The stimulus is a sequence of directed steps followed by a random run.
module tb_my_if_rx_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic [LW-1:0]     level;
`ifdef MY_IF_RX_STATS_EN
  logic [15:0]       stat_accepted, stat_stalled;
`endif

  my_if_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .level(level)
`ifdef MY_IF_RX_STATS_EN
    , .stat_accepted(stat_accepted), .stat_stalled(stat_stalled)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] mdl[$];
  int m_acc = 0;
  int m_stl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag);
    int sz;
    sz = mdl.size();
    chk({tag, ".level"},     32'(level),     32'(sz));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(sz < DEPTH));
    chk({tag, ".out_data"},  32'(out_data),  (sz != 0) ? 32'(mdl[0]) : 32'd0);
  endtask

  // The task drives one cycle of inputs and checks the outputs before the edge.
  // It then applies the queue semantics to the model after the edge.
  task automatic cyc(input string tag, input logic iv, input logic [DATA_W-1:0] d,
                     input logic ordy, input logic fl, output logic pushed);
    logic p_push, p_pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    check_outs(tag);
    p_push = iv && (mdl.size() < DEPTH);
    p_pop  = ordy && (mdl.size() > 0);
    if (p_push) m_acc++;
    if (iv && !p_push) m_stl++;
    @(posedge clk);
    if (fl) mdl.delete();
    else begin
      if (p_pop)  void'(mdl.pop_front());
      if (p_push) mdl.push_back(d);
    end
    pushed = p_push;
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #2;
    mdl.delete(); m_acc = 0; m_stl = 0;
    chk({tag, ".rst_level"}, 32'(level),     32'd0);
    chk({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs({tag, ".post"});
  endtask

  initial begin
    logic pd;
    int acc_cnt;
    logic [DATA_W-1:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    // Hold reset for a few cycles, then release it.
    repeat (2) @(posedge clk);
    do_reset("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_data", 32'(out_data), 32'd0);

    // Fill the FIFO with four bytes while the consumer is stalled.
    for (int i = 0; i < 4; i++) cyc("fill", 1'b1, fill[i], 1'b0, 1'b0, pd);
    check_outs("fill.end");
    chk("fill.level",    32'(level),    32'd4);
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    chk("fill.head",     32'(out_data), 32'h11);

    // At full, a push and a pop request together perform only the pop.
    cyc("fullpop", 1'b1, 8'h55, 1'b1, 1'b0, pd);
    chk("fullpop.nopush", 32'(pd),       32'd0);
    chk("fullpop.level",  32'(level),    32'd3);
    chk("fullpop.head",   32'(out_data), 32'h22);
    cyc("fullpop2", 1'b1, 8'h55, 1'b0, 1'b0, pd);
    chk("fullpop2.level", 32'(level), 32'd4);

    // Drain the FIFO and check the bytes come out in order.
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0, pd);
    check_outs("drain.end");
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Push and pop in the same cycle at level 2.
    cyc("conc", 1'b1, 8'h66, 1'b0, 1'b0, pd);
    cyc("conc", 1'b1, 8'h77, 1'b0, 1'b0, pd);
    cyc("conc", 1'b1, 8'hA5, 1'b1, 1'b0, pd);
    chk("conc.level", 32'(level),    32'd2);
    chk("conc.head",  32'(out_data), 32'h77);

    // Flush at level 3 while the producer is valid. The byte that cycle is dropped.
    cyc("flpre", 1'b1, 8'h88, 1'b0, 1'b0, pd);
    cyc("flush", 1'b1, 8'h99, 1'b0, 1'b1, pd);
    check_outs("flush.end");
    chk("flush.level", 32'(level),     32'd0);
    chk("flush.valid", 32'(out_valid), 32'd0);

    // Assert reset in the middle of traffic.
    cyc("mid", 1'b1, 8'h12, 1'b0, 1'b0, pd);
    cyc("mid", 1'b1, 8'h34, 1'b0, 1'b0, pd);
    do_reset("midrst");

    // Random run: random stalls and occasional flushes until 20 bytes are accepted.
    acc_cnt = 0;
    for (int c = 0; c < 400 && acc_cnt < 20; c++) begin
      cyc("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0), pd);
      if (pd) acc_cnt++;
    end
    chk("rand.done", 32'(acc_cnt), 32'd20);
    for (int c = 0; c < 8; c++) cyc("rdrain", 1'b0, 8'h00, 1'b1, 1'b0, pd);
    check_outs("rdrain.end");

`ifdef MY_IF_RX_STATS_EN
    // Statistics: 10 accepted bytes and 5 stall cycles, with a flush in between.
    do_reset("stat");
    for (int i = 0; i < 4; i++) cyc("st_fill", 1'b1, 8'(i), 1'b0, 1'b0, pd);
    for (int i = 0; i < 5; i++) cyc("st_stall", 1'b1, 8'hEE, 1'b0, 1'b0, pd);
    cyc("st_flush", 1'b0, 8'h00, 1'b0, 1'b1, pd);
    for (int i = 0; i < 6; i++) cyc("st_more", 1'b1, 8'(i + 16), 1'b1, 1'b0, pd);
    chk("stat.acc_model", 32'(stat_accepted), 32'(m_acc));
    chk("stat.stl_model", 32'(stat_stalled),  32'(m_stl));
    chk("stat.accepted",  32'(stat_accepted), 32'd10);
    chk("stat.stalled",   32'(stat_stalled),  32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety net: stop the run if the bench stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
